// File: rtl/ei_axi4_rd_arbiter.sv
// rtl/ei_axi4_rd_arbiter.sv - round-robin arbiter sharing one AXI4 read slave port among NUM_MST masters
module ei_axi4_rd_arbiter #(
    parameter int NUM_MST    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int GW        = $clog2(NUM_MST)
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_MST*ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_MST*8-1:0]          m_arlen,
    input  logic [NUM_MST*3-1:0]          m_arsize,
    input  logic [NUM_MST*2-1:0]          m_arburst,
    input  logic [NUM_MST-1:0]            m_arvalid,
    output logic [NUM_MST-1:0]            m_arready,
    output logic [NUM_MST*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MST*2-1:0]          m_rresp,
    output logic [NUM_MST-1:0]            m_rlast,
    output logic [NUM_MST-1:0]            m_rvalid,
    input  logic [NUM_MST-1:0]            m_rready,
    output logic [ADDR_WIDTH-1:0]         s_araddr,
    output logic [7:0]                    s_arlen,
    output logic [2:0]                    s_arsize,
    output logic [1:0]                    s_arburst,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_WIDTH-1:0]         s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rlast,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          len_err
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [7:0]      len_q, len_d;
    logic            len_err_q, len_err_d;

    logic [GW-1:0]   win_idx;
    int              scan_idx;
    logic            ar_hs;
    logic            r_hs;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        win_idx  = rr_ptr_q;
        scan_idx = 0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_MST) scan_idx = scan_idx - NUM_MST;
            if (m_arvalid[GW'(scan_idx)]) win_idx = GW'(scan_idx);
        end
    end

    always_comb begin
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_arburst = '0;
        s_arvalid = 1'b0;
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rlast   = '0;
        m_rvalid  = '0;
        s_rready  = 1'b0;
        if (state_q == S_ADDR) begin
            s_araddr           = m_araddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_arlen            = m_arlen[grant_q*8 +: 8];
            s_arsize           = m_arsize[grant_q*3 +: 3];
            s_arburst          = m_arburst[grant_q*2 +: 2];
            s_arvalid          = m_arvalid[grant_q];
            m_arready[grant_q] = s_arready;
        end
        if (state_q == S_DATA) begin
            m_rdata[grant_q*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
            m_rresp[grant_q*2 +: 2]                   = s_rresp;
            m_rlast[grant_q]                          = s_rlast;
            m_rvalid[grant_q]                         = s_rvalid;
            s_rready                                  = m_rready[grant_q];
        end
    end

    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        len_err_d  = len_err_q;
        case (state_q)
            S_IDLE: begin
                if (|m_arvalid) begin
                    grant_d = win_idx;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ar_hs) begin
                    len_d      = s_arlen;
                    beat_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
                    // beat_cnt_q is the index of the current beat; the last one must equal arlen.
                    if (s_rlast) begin
                        if (beat_cnt_q != len_q) len_err_d = 1'b1;
                        rr_ptr_d = (grant_q == GW'(NUM_MST - 1)) ? '0 : grant_q + 1'b1;
                        state_d  = S_IDLE;
                    end else if (beat_cnt_q == len_q) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            len_err_q  <= len_err_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);
    assign len_err  = len_err_q;

endmodule
